// File: rtl/fw_pkg.sv
// Shared definitions for the rolling-sum front end: window FSM states, default sample width
// and the offset-binary bias position used when converting signed samples.
package fw_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam int DEF_BITS_PER_ELEM = 8;

   // Offset-binary bias is 2^(width - OFFSET_BIAS_SHIFT), i.e. the sample MSB.
   localparam int OFFSET_BIAS_SHIFT = 1;

endpackage

// File: rtl/sample_window_mem.sv
// Window storage: NUM_ELEM x BITS_PER_ELEM entries, one write port, asynchronous read at the
// write pointer so the evicted value is visible before it is overwritten.
module sample_window_mem
   import fw_pkg::*;
#(
   parameter int BITS_PER_ELEM = DEF_BITS_PER_ELEM,
   parameter int NUM_ELEM      = 4,
   parameter int AW            = $clog2(NUM_ELEM)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     wr_en,
   input  logic [AW-1:0]            ptr,
   input  logic [BITS_PER_ELEM-1:0] wr_data,
   output logic [BITS_PER_ELEM-1:0] rd_data
);

   logic [BITS_PER_ELEM-1:0] mem [NUM_ELEM];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ELEM; i++) mem[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < NUM_ELEM; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[ptr] <= wr_data;
      end
   end

   assign rd_data = mem[ptr];

endmodule

// File: rtl/sample_window.sv
// Circular sample window feeding the rolling-sum stage: newest/evicted pair plus start strobe.
// Build option SIGNED_INPUT_EN: two's-complement input converted to offset binary on entry.
module sample_window
   import fw_pkg::*;
#(
   parameter  int BITS_PER_ELEM = DEF_BITS_PER_ELEM,
   parameter  int NUM_ELEM      = 4,
   localparam int AW            = $clog2(NUM_ELEM)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [BITS_PER_ELEM-1:0] i_sample,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic                     i_clear,
   output logic [BITS_PER_ELEM-1:0] o_new,
   output logic [BITS_PER_ELEM-1:0] o_old,
   output logic                     o_start_calc,
   output logic [AW:0]              o_fill_cnt,
   output logic                     o_primed
);

`ifdef SIGNED_INPUT_EN
   localparam logic [BITS_PER_ELEM-1:0] CONV_MASK =
      BITS_PER_ELEM'(1) << (BITS_PER_ELEM - OFFSET_BIAS_SHIFT);
`else
   localparam logic [BITS_PER_ELEM-1:0] CONV_MASK = '0;
`endif
   localparam logic [AW:0] FULL_CNT = (AW+1)'(NUM_ELEM);

   state_t                   state, state_nxt;
   logic [AW-1:0]            wr_ptr;
   logic [BITS_PER_ELEM-1:0] stored;
   logic [BITS_PER_ELEM-1:0] evicted;
   logic                     transfer;

   // Adding the bias equals flipping the MSB; the mask is zero when input is already offset binary.
   assign stored   = i_sample ^ CONV_MASK;
   assign transfer = i_valid & o_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      o_ready      = 1'b0;
      o_start_calc = 1'b0;
      case (state)
         ST_IDLE: begin
            o_ready = ~i_clear;
            if (transfer) state_nxt = ST_CALC;
         end
         ST_CALC: begin
            o_start_calc = 1'b1;
            state_nxt    = ST_HOLD;
         end
         ST_HOLD: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (i_clear) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         o_new      <= '0;
         o_old      <= '0;
         o_fill_cnt <= '0;
      end else if (i_clear) begin
         wr_ptr     <= '0;
         o_new      <= '0;
         o_old      <= '0;
         o_fill_cnt <= '0;
      end else if (transfer) begin
         o_new  <= stored;
         o_old  <= evicted;
         wr_ptr <= wr_ptr + 1'b1;
         if (o_fill_cnt != FULL_CNT) o_fill_cnt <= o_fill_cnt + 1'b1;
      end
   end

   assign o_primed = (o_fill_cnt == FULL_CNT);

   sample_window_mem #(
      .BITS_PER_ELEM (BITS_PER_ELEM),
      .NUM_ELEM      (NUM_ELEM),
      .AW            (AW)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (i_clear),
      .wr_en   (transfer),
      .ptr     (wr_ptr),
      .wr_data (stored),
      .rd_data (evicted)
   );

endmodule

// File: tb/tb_sample_window.sv
// Bench for sample_window: table vectors, hand sequences for reset/stream/clear, and a randomized
// run against a FIFO-style window model.
module tb_sample_window;

   localparam int W = 8;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] i_sample;
   logic         i_valid;
   logic         o_ready;
   logic         i_clear;
   logic [W-1:0] o_new;
   logic [W-1:0] o_old;
   logic         o_start_calc;
   logic [2:0]   o_fill_cnt;
   logic         o_primed;

   int n_checks = 0;
   int n_errors = 0;

   sample_window #(.BITS_PER_ELEM(W), .NUM_ELEM(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_sample     (i_sample),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_clear      (i_clear),
      .o_new        (o_new),
      .o_old        (o_old),
      .o_start_calc (o_start_calc),
      .o_fill_cnt   (o_fill_cnt),
      .o_primed     (o_primed)
   );

   always #5 clk = ~clk;

   // Reference window: a queue holding the last N stored values, oldest first.
   logic [W-1:0] win_q[$];
   int           fill_m;

   function automatic logic [W-1:0] conv(input logic [W-1:0] s);
`ifdef SIGNED_INPUT_EN
      return W'((int'(s) + 128) % 256);
`else
      return s;
`endif
   endfunction

   task automatic model_reset();
      win_q.delete();
      for (int i = 0; i < N; i++) win_q.push_back('0);
      fill_m = 0;
   endtask

   task automatic model_accept(input logic [W-1:0] s, output logic [W-1:0] en, output logic [W-1:0] eo);
      en = conv(s);
      eo = win_q.pop_front();
      win_q.push_back(en);
      if (fill_m < N) fill_m++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Performs one transfer and returns positioned in the ST_CALC cycle.
   task automatic send(input logic [W-1:0] s);
      logic [W-1:0] en, eo;
      int wait_cyc;
      wait_cyc = 0;
      while (!o_ready && wait_cyc < 10) begin
         step();
         wait_cyc++;
      end
      if (!o_ready) chk("ready_timeout", 32'(o_ready), 32'd1);
      i_sample = s;
      i_valid  = 1'b1;
      model_accept(s, en, eo);
      step();
      i_valid = 1'b0;
      chk("start_calc", 32'(o_start_calc), 32'd1);
      chk("new", 32'(o_new), 32'(en));
      chk("old", 32'(o_old), 32'(eo));
      chk("fill", 32'(o_fill_cnt), 32'(fill_m));
      chk("primed", 32'(o_primed), 32'(fill_m == N));
   endtask

   task automatic finish_txn();
      step();
      chk("hold_no_start", 32'(o_start_calc), 32'd0);
      chk("hold_not_ready", 32'(o_ready), 32'd0);
      step();
      chk("idle_ready", 32'(o_ready), 32'd1);
   endtask

   typedef struct {
      logic [W-1:0] sample;
      logic         old_zero;
      logic [W-1:0] old_sample;
      int           fill;
      logic         primed;
   } fill_vec_t;

   typedef struct {
      logic [W-1:0] sample;
      logic [W-1:0] exp_new;
   } conv_vec_t;

   fill_vec_t fill_tab[6];
   conv_vec_t conv_tab[3];

   initial begin
      logic [W-1:0] en, eo, s;
      logic [W-1:0] exp_old;
      logic         was_ready;
      int           transfers;

      fill_tab[0] = '{8'd10, 1'b1, 8'd0,  1, 1'b0};
      fill_tab[1] = '{8'd20, 1'b1, 8'd0,  2, 1'b0};
      fill_tab[2] = '{8'd30, 1'b1, 8'd0,  3, 1'b0};
      fill_tab[3] = '{8'd40, 1'b1, 8'd0,  4, 1'b1};
      fill_tab[4] = '{8'd50, 1'b0, 8'd10, 4, 1'b1};
      fill_tab[5] = '{8'd60, 1'b0, 8'd20, 4, 1'b1};
`ifdef SIGNED_INPUT_EN
      conv_tab[0] = '{8'h80, 8'h00};
      conv_tab[1] = '{8'h7F, 8'hFF};
      conv_tab[2] = '{8'h00, 8'h80};
`else
      conv_tab[0] = '{8'h80, 8'h80};
      conv_tab[1] = '{8'h7F, 8'h7F};
      conv_tab[2] = '{8'h00, 8'h00};
`endif

      rst_n = 1'b0; i_sample = '0; i_valid = 1'b0; i_clear = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      step();
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_new", 32'(o_new), 32'd0);
      chk("rst_old", 32'(o_old), 32'd0);
      chk("rst_fill", 32'(o_fill_cnt), 32'd0);
      chk("rst_primed", 32'(o_primed), 32'd0);

      // Reset asserted in ST_CALC drops the strobe without waiting for a clock.
      send(8'h33);
      rst_n = 1'b0;
      #1;
      chk("rst_async_start", 32'(o_start_calc), 32'd0);
      chk("rst_async_new", 32'(o_new), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step();
      chk("rst2_ready", 32'(o_ready), 32'd1);
      chk("rst2_old", 32'(o_old), 32'd0);
      chk("rst2_fill", 32'(o_fill_cnt), 32'd0);
      chk("rst2_primed", 32'(o_primed), 32'd0);

      // Fill and wrap from table.
      foreach (fill_tab[i]) begin
         send(fill_tab[i].sample);
         exp_old = fill_tab[i].old_zero ? '0 : conv(fill_tab[i].old_sample);
         chk("tab_new", 32'(o_new), 32'(conv(fill_tab[i].sample)));
         chk("tab_old", 32'(o_old), 32'(exp_old));
         chk("tab_fill", 32'(o_fill_cnt), 32'(fill_tab[i].fill));
         chk("tab_primed", 32'(o_primed), 32'(fill_tab[i].primed));
         finish_txn();
         chk("tab_hold_new", 32'(o_new), 32'(conv(fill_tab[i].sample)));
      end

      // Streaming with i_valid held high.
      transfers = 0;
      for (int c = 0; c < 12; c++) begin
         i_valid  = 1'b1;
         s        = W'($urandom);
         i_sample = s;
         was_ready = o_ready;
         chk("stream_ready", 32'(o_ready), 32'(c % 3 == 0));
         if (was_ready) begin
            model_accept(s, en, eo);
            transfers++;
         end
         step();
         if (was_ready) begin
            chk("stream_start", 32'(o_start_calc), 32'd1);
            chk("stream_new", 32'(o_new), 32'(en));
            chk("stream_old", 32'(o_old), 32'(eo));
         end
      end
      i_valid = 1'b0;
      chk("stream_transfers", 32'(transfers), 32'd4);

      // Clear in ST_CALC beats a concurrent valid.
      send(8'h55);
      i_clear  = 1'b1;
      i_valid  = 1'b1;
      i_sample = 8'h99;
      #1;
      chk("clr_ready_low", 32'(o_ready), 32'd0);
      step();
      i_clear = 1'b0;
      i_valid = 1'b0;
      model_reset();
      #1;
      chk("clr_idle_ready", 32'(o_ready), 32'd1);
      chk("clr_start", 32'(o_start_calc), 32'd0);
      chk("clr_fill", 32'(o_fill_cnt), 32'd0);
      chk("clr_new", 32'(o_new), 32'd0);
      chk("clr_old", 32'(o_old), 32'd0);
      send(8'd70);
      chk("clr_70_old", 32'(o_old), 32'd0);
      chk("clr_70_fill", 32'(o_fill_cnt), 32'd1);
      finish_txn();

      // Input conversion vectors.
      foreach (conv_tab[i]) begin
         send(conv_tab[i].sample);
         chk("conv_new", 32'(o_new), 32'(conv_tab[i].exp_new));
         finish_txn();
      end

      // Randomized traffic with gaps and occasional clears.
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            i_clear = 1'b1;
            #1;
            chk("rnd_clr_ready", 32'(o_ready), 32'd0);
            step();
            i_clear = 1'b0;
            model_reset();
            chk("rnd_clr_fill", 32'(o_fill_cnt), 32'd0);
            chk("rnd_clr_new", 32'(o_new), 32'd0);
         end else begin
            repeat ($urandom_range(0, 2)) step();
            send(W'($urandom));
            finish_txn();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1);
   end

endmodule
